// File: rtl/sensor_irq_ctrl_if.sv
// -----------------------------------------------------------------------------
// sensor_irq_ctrl_if
//   CPU-side register port of the interrupt controller.
//
//   reg_req_i    one-cycle access strobe
//   reg_we_i     1 = write, 0 = read
//   reg_addr_i   byte address, bits [4:2] select the register
//   reg_wdata_i  write data
//   reg_rdata_o  read data, valid while reg_rvalid_o = 1, 0 otherwise
//   reg_rvalid_o one-cycle pulse the cycle after a read request
//
//   master: the CPU (drives requests); slave: the controller.
// -----------------------------------------------------------------------------
interface sensor_irq_ctrl_if;
   logic        reg_req_i;
   logic        reg_we_i;
   logic [4:0]  reg_addr_i;
   logic [31:0] reg_wdata_i;
   logic [31:0] reg_rdata_o;
   logic        reg_rvalid_o;

   modport master (
      output reg_req_i, reg_we_i, reg_addr_i, reg_wdata_i,
      input  reg_rdata_o, reg_rvalid_o
   );

   modport slave (
      input  reg_req_i, reg_we_i, reg_addr_i, reg_wdata_i,
      output reg_rdata_o, reg_rvalid_o
   );
endinterface

// File: rtl/sensor_irq_ctrl.sv
// -----------------------------------------------------------------------------
// sensor_irq_ctrl
//   Interrupt controller for the sensor subsystem. Latches up to NSRC request
//   lines (source 0 = sensor controller), applies per-source enables, picks
//   the lowest-index pending enabled source and drives one CPU interrupt.
//   The CPU claims through a CLAIM read and completes with a CLAIM write of
//   the claimed id; only one source is in service at a time.
//
//   Ports:
//     clk       clock, rising edge
//     rst       asynchronous active-low reset
//     src_i     raw interrupt lines, src_i[0] = sensor controller interrupt
//     bus       register port (sensor_irq_ctrl_if.slave)
//     irq_o     interrupt to the CPU, high only while asserting a candidate
//     irq_id_o  id+1 of the current candidate, 0 = none
//
//   Registers (addr[4:2]): 0 ENABLE, 1 PENDING, 2 MODE, 3 CLAIM, 4 STATUS.
//
//   Build option: define SENSOR_IRQ_EDGE_EN to build the MODE register and
//   the per-source edge latches. Without it every source is level-sensitive,
//   MODE reads 0 and ignores writes.
// -----------------------------------------------------------------------------
module sensor_irq_ctrl #(
   parameter int NSRC = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NSRC-1:0]  src_i,
   sensor_irq_ctrl_if.slave bus,
   output logic             irq_o,
   output logic [3:0]       irq_id_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } state_e;

   localparam logic [2:0] A_ENABLE  = 3'd0;
   localparam logic [2:0] A_PENDING = 3'd1;
   localparam logic [2:0] A_MODE    = 3'd2;
   localparam logic [2:0] A_CLAIM   = 3'd3;
   localparam logic [2:0] A_STATUS  = 3'd4;

   state_e           state_q, state_d;
   logic [NSRC-1:0]  src_q;
   logic [NSRC-1:0]  enable_q, enable_d;
   logic [3:0]       in_svc_q, in_svc_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             rvalid_q;

   logic [NSRC-1:0]  mode;
   logic [NSRC-1:0]  edge_pend;
   logic [NSRC-1:0]  svc_mask;
   logic [NSRC-1:0]  pending;
   logic [3:0]       cand_id;
   logic [2:0]       reg_sel;
   logic             rd_req, wr_req;
   logic             claim_rd, claim_wr, claim_take, complete;
   logic             unused_addr_lsbs;

   assign reg_sel    = bus.reg_addr_i[4:2];
   assign rd_req     = bus.reg_req_i & ~bus.reg_we_i;
   assign wr_req     = bus.reg_req_i &  bus.reg_we_i;
   assign claim_rd   = rd_req & (reg_sel == A_CLAIM);
   assign claim_wr   = wr_req & (reg_sel == A_CLAIM);
   // A claim only takes effect while an interrupt is actually being offered.
   assign claim_take = claim_rd & (state_q == ST_ASSERT) & (cand_id != 4'd0);
   assign complete   = claim_wr & (state_q == ST_SERVICE) &
                       (bus.reg_wdata_i == {28'd0, in_svc_q});
   assign unused_addr_lsbs = ^bus.reg_addr_i[1:0];

   // The source in service is hidden from level pending so it cannot re-offer
   // itself until the ISR completes it.
   always_comb begin
      // NOTE: every signal driven from always_comb gets a default first so no
      // path through the block leaves it unassigned and infers a latch.
      svc_mask = '0;
      for (int i = 0; i < NSRC; i++) begin
         svc_mask[i] = (state_q == ST_SERVICE) && (in_svc_q == 4'(i + 1));
      end
   end

   assign pending = (mode & edge_pend) | (~mode & src_q & ~svc_mask);

   // Fixed priority: scan from the top so the lowest index is written last.
   always_comb begin
      cand_id = 4'd0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (pending[i] && enable_q[i]) cand_id = 4'(i + 1);
      end
   end

`ifdef SENSOR_IRQ_EDGE_EN
   logic [NSRC-1:0] mode_q, mode_d;
   logic [NSRC-1:0] edge_q, edge_d;
   logic [NSRC-1:0] claim_clr;

   always_comb begin
      mode_d    = mode_q;
      claim_clr = '0;
      if (wr_req && (reg_sel == A_MODE)) mode_d = bus.reg_wdata_i[NSRC-1:0];
      for (int i = 0; i < NSRC; i++) begin
         claim_clr[i] = claim_take && (cand_id == 4'(i + 1));
      end
      // A new edge in the claim cycle wins over the clear, so it is not lost.
      edge_d = (edge_q & ~claim_clr) | (src_i & ~src_q & mode_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q <= '0;
         edge_q <= '0;
      end else begin
         mode_q <= mode_d;
         edge_q <= edge_d;
      end
   end

   assign mode      = mode_q;
   assign edge_pend = edge_q;
`else
   assign mode      = '0;
   assign edge_pend = '0;
`endif

   // Claim / complete state machine.
   always_comb begin
      state_d  = state_q;
      in_svc_d = in_svc_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cand_id != 4'd0) state_d = ST_ASSERT;
         end
         ST_ASSERT: begin
            if (claim_take) begin
               state_d  = ST_SERVICE;
               in_svc_d = cand_id;
            end else if (cand_id == 4'd0) begin
               state_d = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (complete) begin
               state_d  = ST_IDLE;
               in_svc_d = 4'd0;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            in_svc_d = 4'd0;
         end
      endcase
   end

   always_comb begin
      enable_d = enable_q;
      if (wr_req && (reg_sel == A_ENABLE)) enable_d = bus.reg_wdata_i[NSRC-1:0];
   end

   // Read data is captured one cycle after the request and is 0 otherwise.
   always_comb begin
      rdata_d = '0;
      if (rd_req) begin
         case (reg_sel)
            A_ENABLE:  rdata_d[NSRC-1:0] = enable_q;
            A_PENDING: rdata_d[NSRC-1:0] = pending;
            A_MODE:    rdata_d[NSRC-1:0] = mode;
            A_CLAIM:   if (state_q == ST_ASSERT) rdata_d[3:0] = cand_id;
            A_STATUS:  rdata_d[7:0] = {in_svc_q, 2'b00, state_q};
            default:   rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         src_q    <= '0;
         enable_q <= '0;
         in_svc_q <= 4'd0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples the pre-edge value of every other flop.
         state_q  <= state_d;
         src_q    <= src_i;
         enable_q <= enable_d;
         in_svc_q <= in_svc_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rd_req;
      end
   end

   // Gating with the candidate drops the interrupt as soon as it is withdrawn.
   assign irq_o            = (state_q == ST_ASSERT) && (cand_id != 4'd0);
   assign irq_id_o         = cand_id;
   assign bus.reg_rdata_o  = rdata_q;
   assign bus.reg_rvalid_o = rvalid_q;

endmodule

// File: tb/tb_sensor_irq_ctrl.sv
module tb_sensor_irq_ctrl;

   localparam int NSRC = 4;
`ifdef SENSOR_IRQ_EDGE_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif

   localparam logic [4:0] R_EN   = 5'h00;
   localparam logic [4:0] R_PEND = 5'h04;
   localparam logic [4:0] R_MODE = 5'h08;
   localparam logic [4:0] R_CLM  = 5'h0C;
   localparam logic [4:0] R_STAT = 5'h10;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NSRC-1:0] src_i = '0;
   logic            irq_o;
   logic [3:0]      irq_id_o;

   sensor_irq_ctrl_if bus_if ();

   sensor_irq_ctrl #(.NSRC(NSRC)) dut (
      .clk      (clk),
      .rst      (rst),
      .src_i    (src_i),
      .bus      (bus_if.slave),
      .irq_o    (irq_o),
      .irq_id_o (irq_id_o)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: controller state in plain terms (0 idle, 1 asserting,
   // 2 in service), sources numbered by id = index + 1.
   bit [NSRC-1:0] m_en, m_mode, m_srcq, m_edge;
   int            m_state, m_svc;
   bit            m_rvalid;
   bit [31:0]     m_rdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit [NSRC-1:0] m_pending();
      bit [NSRC-1:0] p;
      for (int i = 0; i < NSRC; i++) begin
         if (m_mode[i]) p[i] = m_edge[i];
         else           p[i] = m_srcq[i] && !(m_state == 2 && m_svc == i + 1);
      end
      return p;
   endfunction

   function automatic int m_cand();
      bit [NSRC-1:0] p;
      p = m_pending();
      for (int i = 0; i < NSRC; i++) if (p[i] && m_en[i]) return i + 1;
      return 0;
   endfunction

   task automatic model_reset();
      m_en = '0; m_mode = '0; m_srcq = '0; m_edge = '0;
      m_state = 0; m_svc = 0; m_rvalid = 1'b0; m_rdata = '0;
   endtask

   // One clock: predict from pre-edge inputs, advance, compare, drop strobe.
   task automatic step();
      int            c, sel, n_state, n_svc;
      bit            rd, wr;
      bit [NSRC-1:0] n_en, n_mode, n_edge, n_srcq;
      bit [31:0]     n_rdata, wd;
      c       = m_cand();
      sel     = int'(bus_if.reg_addr_i[4:2]);
      rd      = bus_if.reg_req_i && !bus_if.reg_we_i;
      wr      = bus_if.reg_req_i && bus_if.reg_we_i;
      wd      = bus_if.reg_wdata_i;
      n_en    = m_en; n_mode = m_mode; n_edge = m_edge; n_srcq = src_i;
      n_state = m_state; n_svc = m_svc; n_rdata = '0;
      if (rd) begin
         case (sel)
            0: n_rdata = 32'(m_en);
            1: n_rdata = 32'(m_pending());
            2: n_rdata = 32'(m_mode);
            3: n_rdata = (m_state == 1) ? 32'(c) : 32'd0;
            4: n_rdata = 32'(m_svc * 16 + m_state);
            default: n_rdata = '0;
         endcase
      end
      if (EDGE) begin
         for (int i = 0; i < NSRC; i++) begin
            n_edge[i] = (src_i[i] && !m_srcq[i] && m_mode[i]) ||
                        (m_edge[i] && !(m_state == 1 && rd && sel == 3 && c == i + 1));
         end
      end
      if (m_state == 0) begin
         if (c != 0) n_state = 1;
      end else if (m_state == 1) begin
         if (rd && sel == 3 && c != 0) begin n_state = 2; n_svc = c; end
         else if (c == 0) n_state = 0;
      end else begin
         if (wr && sel == 3 && wd == 32'(m_svc)) begin n_state = 0; n_svc = 0; end
      end
      if (wr && sel == 0) n_en = wd[NSRC-1:0];
      if (wr && sel == 2 && EDGE) n_mode = wd[NSRC-1:0];
      @(posedge clk);
      #1;
      m_en = n_en; m_mode = n_mode; m_edge = n_edge; m_srcq = n_srcq;
      m_state = n_state; m_svc = n_svc; m_rvalid = rd; m_rdata = n_rdata;
      check("irq_o",    32'(irq_o),               32'(m_state == 1 && m_cand() != 0));
      check("irq_id_o", 32'(irq_id_o),            32'(m_cand()));
      check("rvalid",   32'(bus_if.reg_rvalid_o), 32'(m_rvalid));
      check("rdata",    bus_if.reg_rdata_o,       m_rdata);
      bus_if.reg_req_i = 1'b0;
      bus_if.reg_we_i  = 1'b0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      bus_if.reg_req_i = 1'b1; bus_if.reg_we_i = 1'b1;
      bus_if.reg_addr_i = a;   bus_if.reg_wdata_i = d;
      step();
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      bus_if.reg_req_i = 1'b1; bus_if.reg_we_i = 1'b0;
      bus_if.reg_addr_i = a;   bus_if.reg_wdata_i = '0;
      step();
      d = bus_if.reg_rdata_o;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int          op;
      logic [1:0]  lo;
      bus_if.reg_req_i = 1'b0; bus_if.reg_we_i = 1'b0;
      bus_if.reg_addr_i = '0;  bus_if.reg_wdata_i = '0;
      model_reset();

      // Reset values
      #1 rst = 1'b0;
      #1;
      check("rst irq_o",    32'(irq_o), 32'd0);
      check("rst irq_id_o", 32'(irq_id_o), 32'd0);
      check("rst rvalid",   32'(bus_if.reg_rvalid_o), 32'd0);
      check("rst rdata",    bus_if.reg_rdata_o, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Sensor source 0: irq two cycles after the rising line
      wr(R_EN, 32'h1);
      idle(3);
      src_i = 4'b0001;
      step();
      check("src0 irq t+1", 32'(irq_o), 32'd0);
      step();
      check("src0 irq t+2", 32'(irq_o), 32'd1);
      check("src0 id t+2",  32'(irq_id_o), 32'd1);
      rd(R_CLM, d);
      check("src0 claim", d, 32'd1);
      src_i = '0;
      wr(R_CLM, 32'd1);
      idle(2);

      // Priority, claim, mismatched complete, re-claim
      wr(R_EN, 32'hF);
      src_i = 4'b0110;
      idle(2);
      rd(R_CLM, d);
      check("prio claim", d, 32'd2);
      check("irq falls after claim", 32'(irq_o), 32'd0);
      wr(R_CLM, 32'd3);
      rd(R_STAT, d);
      check("status in service 2", d, 32'h22);
      src_i = 4'b0100;
      wr(R_CLM, 32'd2);
      rd(R_STAT, d);
      check("status idle after complete", 32'(d[1:0]), 32'd0);
      idle(1);
      rd(R_CLM, d);
      check("re-claim", d, 32'd3);
      src_i = '0;
      wr(R_CLM, 32'd3);
      idle(2);

      // Level source held through complete, then disable while asserting
      wr(R_EN, 32'h1);
      src_i = 4'b0001;
      idle(2);
      rd(R_CLM, d);
      check("level claim", d, 32'd1);
      wr(R_CLM, 32'd1);
      check("level irq t+1", 32'(irq_o), 32'd0);
      step();
      check("level re-assert t+2", 32'(irq_o), 32'd1);
      wr(R_EN, 32'h0);
      check("disable irq drop", 32'(irq_o), 32'd0);
      idle(1);
      rd(R_STAT, d);
      check("disable state idle", 32'(d[1:0]), 32'd0);
      src_i = '0;

      // Address decode
      wr(5'h03, 32'h5);
      rd(5'h02, d);
      check("addr lsbs ignored", d, 32'h5);
      rd(5'h14, d);
      check("unmapped 0x14", d, 32'd0);
      wr(5'h1C, 32'hFFFF_FFFF);
      rd(5'h1F, d);
      check("unmapped 0x1C", d, 32'd0);
      rd(R_EN, d);
      check("unmapped write ignored", d, 32'h5);
      wr(R_EN, 32'h0);

      // Edge mode
      wr(R_MODE, 32'h2);
      if (EDGE) begin
         wr(R_EN, 32'hF);
         src_i = 4'b0010; step();
         src_i = '0;      step();
         rd(R_PEND, d);
         check("edge latched", d, 32'h2);
         rd(R_CLM, d);
         check("edge claim", d, 32'd2);
         rd(R_PEND, d);
         check("edge cleared by claim", d, 32'h0);
         wr(R_CLM, 32'd2);
         src_i = 4'b0010; step();
         src_i = '0;      step();
         src_i = 4'b0010;
         rd(R_CLM, d);
         check("edge claim 2", d, 32'd2);
         src_i = '0;
         rd(R_PEND, d);
         check("edge set beats clear", d, 32'h2);
         wr(R_CLM, 32'd2);
         idle(1);
         rd(R_CLM, d);
         check("edge claim 3", d, 32'd2);
         wr(R_CLM, 32'd2);
         wr(R_MODE, 32'h0);
         wr(R_EN, 32'h0);
      end else begin
         rd(R_MODE, d);
         check("mode absent", d, 32'h0);
      end
      idle(2);

      // Reset while in service
      wr(R_EN, 32'hF);
      src_i = 4'b0011;
      idle(2);
      rd(R_CLM, d);
      check("pre-reset claim", d, 32'd1);
      check("pre-reset next id", 32'(irq_id_o), 32'd2);
      rd(R_EN, d);
      rst = 1'b0;
      src_i = '0;
      #1;
      check("async rst irq_o",    32'(irq_o), 32'd0);
      check("async rst irq_id_o", 32'(irq_id_o), 32'd0);
      check("async rst rvalid",   32'(bus_if.reg_rvalid_o), 32'd0);
      check("async rst rdata",    bus_if.reg_rdata_o, 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      rd(R_CLM, d);
      check("claim after reset", d, 32'd0);
      rd(R_STAT, d);
      check("status after reset", d, 32'd0);

      // Randomized traffic against the model
      for (int k = 0; k < 500; k++) begin
         if ($urandom_range(0, 3) == 0) src_i = NSRC'($urandom);
         op = int'($urandom_range(0, 9));
         lo = 2'($urandom);
         case (op)
            4: rd({3'($urandom_range(0, 7)), lo}, d);
            5: wr({3'd0, lo}, $urandom);
            6: wr({3'd2, lo}, $urandom);
            7: rd({3'd3, lo}, d);
            8: wr({3'd3, lo}, ($urandom_range(0, 2) != 0) ? 32'(m_svc)
                                                          : 32'($urandom_range(0, 5)));
            9: rd({3'($urandom_range(1, 4)), lo}, d);
            default: step();
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sensor_irq_ctrl.md
# sensor_irq_ctrl

Interrupt controller that consumes the sensor controller's interrupt (`sctrl_int_o`) and up to `NSRC-1` other peripheral interrupt lines, and drives the single external interrupt into the CPU. It latches requests, applies per-source enables, and arbitrates by fixed priority (lowest index wins). The CPU claims and completes interrupts through a simple register port, which lets the sensor ISR drain the buffer and clear the sensor without losing or duplicating events. Source 0 is wired to the sensor controller interrupt.

## Interface
- `NSRC`, default 4: number of interrupt sources, 1..15; source 0 is the sensor controller.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `src_i`  in  NSRC: raw interrupt lines; `src_i[0]` = `sctrl_int_o`.
- `reg_req_i`  in  1: register access strobe, one cycle per access.
- `reg_we_i`  in  1: 1 = write, 0 = read.
- `reg_addr_i`  in  5: byte address; bits [4:2] select the register; bits [1:0] are ignored.
- `reg_wdata_i`  in  32: write data.
- `reg_rdata_o`  out  32: read data; valid while `reg_rvalid_o` = 1; 0 otherwise.
- `reg_rvalid_o`  out  1: one-cycle pulse, the cycle after a read request.
- `irq_o`  out  1: interrupt to the CPU.
- `irq_id_o`  out  4: id+1 of the highest-priority pending enabled source; 0 = none.

## Operation
- Registers:
  - 0x00 ENABLE, RW, bits [NSRC-1:0].
  - 0x04 PENDING, RO.
  - 0x08 MODE, RW; bit = 1 selects edge mode for that source.
  - 0x0C CLAIM: a read returns the current id+1, or 0 if none. A write of id+1 completes that source.
  - 0x10 STATUS, RO: {in_service_id[7:4], state[1:0]}.
  - Other addresses: reads return 0; writes are ignored.
- `src_q` <= `src_i` every cycle.
- Level mode: `pending[i]` = `src_q[i]`, masked while source i is in service.
- Edge mode: a rising edge (`src_i[i]` & ~`src_q[i]`) sets `pending[i]`; a claim of source i clears it. A set and a clear in the same cycle resolve to set.
- Candidate = lowest i with `pending[i]` & `ENABLE[i]`.
- FSM states: IDLE (0), ASSERT (1), SERVICE (2).
  - IDLE -> ASSERT when a candidate exists.
  - ASSERT -> IDLE if the candidate vanishes (source dropped or was disabled).
  - ASSERT -> SERVICE on a CLAIM read returning a nonzero id; that id is latched as `in_service`.
  - SERVICE -> IDLE on a CLAIM write whose data equals `in_service`. A mismatched write is ignored.
- Only one source is in service at a time. Other pending sources wait.
- A CLAIM read while in IDLE or SERVICE returns 0 and has no side effect.
- `irq_o` = 1 only in ASSERT.

## Timing
- Reset values: `irq_o` = 0, `irq_id_o` = 0, `reg_rvalid_o` = 0, `reg_rdata_o` = 0. All registers are 0 (all sources disabled, level mode), FSM is IDLE.
- `src_i` rising at cycle t: `src_q` (level) or `pending` (edge) updates at t+1, and `irq_o` rises at t+2.
- Read: request at t, `reg_rdata_o`/`reg_rvalid_o` at t+1.
- Write: takes effect at t+1.
- The claim's state change (ASSERT -> SERVICE) takes effect at t+1, so `irq_o` falls at t+1.
- The id returned by CLAIM is the candidate at cycle t.
- After a completing write at t, the FSM is IDLE at t+1. If a source is still pending, ASSERT at t+2.
- Level source still high after complete: it re-asserts. Sensor ISR rule: clear the sensor before completing.
- Reset asserted mid-service: all state is cleared asynchronously. Edges seen during reset are lost.

## Configuration
- `SENSOR_IRQ_EDGE_EN` defined:
  - MODE register and edge detection are present.
- `SENSOR_IRQ_EDGE_EN` undefined:
  - All sources are level only.
  - MODE reads 0 and writes are ignored.
  - No edge-latch flops are built.

## Test plan
- Reset, ENABLE=0x1, raise `src_i[0]` at cycle 10 -> `irq_o`=1 at cycle 12, `irq_id_o`=1.
- `src_i`=0b0110, ENABLE=0xF -> CLAIM read returns 2, `irq_o` falls the next cycle. After completion (write 2) and re-claim -> 3.
- Write 3 to CLAIM while in service of id 2 -> ignored; STATUS in_service=2, state=2. Write 2 -> state=0.
- Edge mode (macro on), MODE=0x2, pulse `src_i[1]` for 1 cycle -> PENDING=0x2 latched; claim clears it. A pulse during the claim cycle leaves PENDING=0x2.
- Level source 0 held high through complete -> `irq_o` re-asserts 2 cycles after the complete write. Disable ENABLE[0] in ASSERT -> `irq_o`=0 next cycle, state IDLE.
- Assert `rst` low in SERVICE -> all outputs 0 immediately; after release, CLAIM read returns 0.
